// File: rtl/imem_pkg.sv
// -----------------------------------------------------------------------------
// imem_pkg
// Shared definitions for the instruction-memory port arbiter:
//   IMEM_ADDR_W / IMEM_DATA_W : default word address / data widths
//   LD_CNT_W                  : width of the loader burst counter
//   owner_e                   : which requester owns the read in flight
//   next_owner()              : owner to record for the current cycle's grant
// -----------------------------------------------------------------------------
package imem_pkg;

  localparam int IMEM_ADDR_W = 10;
  localparam int IMEM_DATA_W = 32;
  localparam int LD_CNT_W    = 4;

  typedef enum logic [1:0] {
    OWN_NONE  = 2'd0,
    OWN_FETCH = 2'd1,
    OWN_LOAD  = 2'd2
  } owner_e;

  // Only reads leave a response behind; a loader write records no owner.
  function automatic owner_e next_owner(input logic fetch_gnt,
                                        input logic ld_gnt,
                                        input logic ld_we);
    owner_e own;
    if (ld_gnt && !ld_we) begin
      own = OWN_LOAD;
    end else if (fetch_gnt) begin
      own = OWN_FETCH;
    end else begin
      own = OWN_NONE;
    end
    return own;
  endfunction

endpackage

// File: rtl/imem_arb_core.sv
// -----------------------------------------------------------------------------
// imem_arb_core
// Per-cycle grant logic between the fetch unit and the loader, plus the
// loader burst counter that guarantees fetch progress under contention.
//   CLK_SYS    in   system clock
//   rst        in   asynchronous active-low reset
//   fetch_req  in   fetch request
//   ld_req     in   loader request
//   fetch_gnt  out  fetch granted this cycle (combinational)
//   ld_gnt     out  loader granted this cycle (combinational)
// -----------------------------------------------------------------------------
module imem_arb_core
  import imem_pkg::*;
#(
  parameter int MAX_LD_BURST = 4
) (
  input  logic CLK_SYS,
  input  logic rst,
  input  logic fetch_req,
  input  logic ld_req,
  output logic fetch_gnt,
  output logic ld_gnt
);

  localparam logic [LD_CNT_W-1:0] MAX_CNT = LD_CNT_W'(MAX_LD_BURST);

  logic [LD_CNT_W-1:0] ld_cnt_r;
  logic                ld_cap_s;
  logic                fetch_gnt_s;
  logic                ld_gnt_s;

  // Grant decision: loader first unless it has used up its burst while fetch waits.
  always_comb begin
    fetch_gnt_s = 1'b0;
    ld_gnt_s    = 1'b0;
    ld_cap_s    = (ld_cnt_r == MAX_CNT);
    if (!rst) begin
      fetch_gnt_s = 1'b0;
      ld_gnt_s    = 1'b0;
    end else if (ld_req && (!fetch_req || !ld_cap_s)) begin
      ld_gnt_s = 1'b1;
    end else if (fetch_req) begin
      fetch_gnt_s = 1'b1;
    end else begin
      fetch_gnt_s = 1'b0;
      ld_gnt_s    = 1'b0;
    end
  end

  // Burst counter: counts loader wins only while fetch is being held off.
  always_ff @(posedge CLK_SYS or negedge rst) begin
    if (!rst) begin
      ld_cnt_r <= {LD_CNT_W{1'b0}};
    end else if (!fetch_req || fetch_gnt_s) begin
      ld_cnt_r <= {LD_CNT_W{1'b0}};
    end else if (ld_gnt_s && !ld_cap_s) begin
      ld_cnt_r <= ld_cnt_r + {{(LD_CNT_W-1){1'b0}}, 1'b1};
    end else begin
      ld_cnt_r <= ld_cnt_r;
    end
  end

  assign fetch_gnt = fetch_gnt_s;
  assign ld_gnt    = ld_gnt_s;

endmodule

// File: rtl/imem_port_arbiter.sv
// -----------------------------------------------------------------------------
// imem_port_arbiter
// Shares the single-port synchronous-read instruction memory between the CPU
// fetch unit (read only) and the loader/debug port (read/write). Read data is
// steered back to the issuing requester two edges after its grant.
//   CLK_SYS, rst                   clock, async active-low reset
//   fetch_req/addr -> fetch_gnt    fetch request side
//   fetch_valid, fetch_data        fetch response (registered)
//   ld_req/we/addr/wdata -> ld_gnt loader request side
//   ld_valid, ld_rdata             loader read response (registered)
//   mem_en/we/addr/wdata, mem_rdata instruction memory port
// -----------------------------------------------------------------------------
module imem_port_arbiter
  import imem_pkg::*;
#(
  parameter int ADDR_W       = IMEM_ADDR_W,
  parameter int DATA_W       = IMEM_DATA_W,
  parameter int MAX_LD_BURST = 4
) (
  input  logic              CLK_SYS,
  input  logic              rst,
  input  logic              fetch_req,
  input  logic [ADDR_W-1:0] fetch_addr,
  output logic              fetch_gnt,
  output logic              fetch_valid,
  output logic [DATA_W-1:0] fetch_data,
  input  logic              ld_req,
  input  logic              ld_we,
  input  logic [ADDR_W-1:0] ld_addr,
  input  logic [DATA_W-1:0] ld_wdata,
  output logic              ld_gnt,
  output logic              ld_valid,
  output logic [DATA_W-1:0] ld_rdata,
  output logic              mem_en,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata
);

  logic              fetch_gnt_s;
  logic              ld_gnt_s;
  logic [ADDR_W-1:0] mem_addr_s;
  logic [DATA_W-1:0] mem_wdata_s;
  owner_e            owner_r;
  logic              fetch_valid_r;
  logic [DATA_W-1:0] fetch_data_r;
  logic              ld_valid_r;
  logic [DATA_W-1:0] ld_rdata_r;

  imem_arb_core #(
    .MAX_LD_BURST (MAX_LD_BURST)
  ) u_arb_core (
    .CLK_SYS   (CLK_SYS),
    .rst       (rst),
    .fetch_req (fetch_req),
    .ld_req    (ld_req),
    .fetch_gnt (fetch_gnt_s),
    .ld_gnt    (ld_gnt_s)
  );

  // Memory address/data mux; parked at zero when nobody is granted.
  always_comb begin
    mem_addr_s  = {ADDR_W{1'b0}};
    mem_wdata_s = {DATA_W{1'b0}};
    if (ld_gnt_s) begin
      mem_addr_s  = ld_addr;
      mem_wdata_s = ld_wdata;
    end else if (fetch_gnt_s) begin
      mem_addr_s  = fetch_addr;
      mem_wdata_s = {DATA_W{1'b0}};
    end else begin
      mem_addr_s  = {ADDR_W{1'b0}};
      mem_wdata_s = {DATA_W{1'b0}};
    end
  end

  // Owner of the read whose data appears on mem_rdata next cycle.
  always_ff @(posedge CLK_SYS or negedge rst) begin
    if (!rst) begin
      owner_r <= OWN_NONE;
    end else begin
      owner_r <= next_owner(fetch_gnt_s, ld_gnt_s, ld_we);
    end
  end

  // Response registers: capture mem_rdata for the owner, hold data otherwise.
  always_ff @(posedge CLK_SYS or negedge rst) begin
    if (!rst) begin
      fetch_valid_r <= 1'b0;
      fetch_data_r  <= {DATA_W{1'b0}};
      ld_valid_r    <= 1'b0;
      ld_rdata_r    <= {DATA_W{1'b0}};
    end else begin
      fetch_valid_r <= (owner_r == OWN_FETCH);
      ld_valid_r    <= (owner_r == OWN_LOAD);
      if (owner_r == OWN_FETCH) begin
        fetch_data_r <= mem_rdata;
      end else begin
        fetch_data_r <= fetch_data_r;
      end
      if (owner_r == OWN_LOAD) begin
        ld_rdata_r <= mem_rdata;
      end else begin
        ld_rdata_r <= ld_rdata_r;
      end
    end
  end

  assign fetch_gnt   = fetch_gnt_s;
  assign ld_gnt      = ld_gnt_s;
  assign mem_en      = fetch_gnt_s | ld_gnt_s;
  assign mem_we      = ld_gnt_s & ld_we;
  assign mem_addr    = mem_addr_s;
  assign mem_wdata   = mem_wdata_s;
  assign fetch_valid = fetch_valid_r;
  assign fetch_data  = fetch_data_r;
  assign ld_valid    = ld_valid_r;
  assign ld_rdata    = ld_rdata_r;

endmodule
